// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard of in-flight writes,
// RAW/WAW stall generation and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int REGW   = 5,
    parameter int MAXLAT = 4,
    parameter int LATW   = 3,
    parameter int CNTW   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_wr,
    input  logic [LATW-1:0] id_lat,
    input  logic            pipe_adv,
    output logic            IsStall_IF,
    output logic            IsStall_ID,
    output logic [NREG-1:0] busy,
    output logic [CNTW-1:0] stall_count
);

    localparam logic [LATW-1:0] MAX_L = LATW'(MAXLAT);

    // Register 0 has no storage; it always reads as idle.
    logic [LATW-1:0] cnt [1:NREG-1];

    logic [LATW-1:0] lat_eff;
    logic [LATW-1:0] rs_cnt;
    logic [LATW-1:0] rt_cnt;
    logic [LATW-1:0] rd_cnt;
    logic            raw;
    logic            waw;
    logic            hz;
    logic            iss;
    logic            load_en;

    // Indices of 0 or beyond NREG-1 match no entry and therefore read as 0.
    function automatic logic [LATW-1:0] cnt_of(input logic [REGW-1:0] idx);
        logic [LATW-1:0] v;
        v = '0;
        for (int r = 1; r < NREG; r++) begin
            if (idx == REGW'(r)) v = cnt[r];
        end
        return v;
    endfunction

    always_comb begin
        lat_eff = (id_lat > MAX_L) ? MAX_L : id_lat;
        rs_cnt  = cnt_of(id_rs);
        rt_cnt  = cnt_of(id_rt);
        rd_cnt  = cnt_of(id_rd);
        raw     = (id_rs_used && (rs_cnt != '0)) || (id_rt_used && (rt_cnt != '0));
        // A shorter younger write must wait until it can no longer overtake the older one.
        waw     = id_wr && (rd_cnt > lat_eff);
        hz      = id_valid && (raw || waw) && !reset;
        iss     = id_valid && !hz && pipe_adv;
        load_en = iss && id_wr && (lat_eff != '0);
    end

    assign IsStall_IF = hz;
    assign IsStall_ID = hz;

    // A fresh load wins over the decrement; everything holds while frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 1; r < NREG; r++) cnt[r] <= '0;
        end else if (pipe_adv) begin
            for (int r = 1; r < NREG; r++) begin
                if (load_en && (id_rd == REGW'(r))) begin
                    cnt[r] <= lat_eff;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LATW'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) busy[r] = (cnt[r] != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (hz && (stall_count != '1)) begin
            stall_count <= stall_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table for the
// main scenarios plus a hand-written saturation sequence on a narrow counter.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_rs_used = 1'b0;
    logic        id_rt_used = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_wr = 1'b0;
    logic [2:0]  id_lat = '0;
    logic        pipe_adv = 1'b1;

    logic        stall_if;
    logic        stall_id;
    logic [31:0] busy;
    logic [31:0] stall_count;
    logic        sat_stall_if;
    logic        sat_stall_id;
    logic [31:0] sat_busy;
    logic [3:0]  sat_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_wr(id_wr), .id_lat(id_lat), .pipe_adv(pipe_adv),
        .IsStall_IF(stall_if), .IsStall_ID(stall_id),
        .busy(busy), .stall_count(stall_count)
    );

    hazard_scoreboard #(.CNTW(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_wr(id_wr), .id_lat(id_lat), .pipe_adv(pipe_adv),
        .IsStall_IF(sat_stall_if), .IsStall_ID(sat_stall_id),
        .busy(sat_busy), .stall_count(sat_count)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  rs;
        logic        rsu;
        logic [4:0]  rt;
        logic        rtu;
        logic [4:0]  rd;
        logic        wr;
        logic [2:0]  lat;
        logic        adv;
        logic        chk_state;
        logic        exp_stall;
        logic [31:0] exp_busy;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    // Expected busy/count describe the state seen before this row's clock edge.
    function automatic vec_t mk(input logic rst, input logic valid,
                                input logic [4:0] rs, input logic rsu,
                                input logic [4:0] rt, input logic rtu,
                                input logic [4:0] rd, input logic wr,
                                input logic [2:0] lat, input logic adv,
                                input logic chk_state, input logic exp_stall,
                                input logic [31:0] exp_busy, input logic [31:0] exp_cnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu;
        v.rd = rd; v.wr = wr; v.lat = lat; v.adv = adv; v.chk_state = chk_state;
        v.exp_stall = exp_stall; v.exp_busy = exp_busy; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        id_valid   = v.valid;
        id_rs      = v.rs;
        id_rs_used = v.rsu;
        id_rt      = v.rt;
        id_rt_used = v.rtu;
        id_rd      = v.rd;
        id_wr      = v.wr;
        id_lat     = v.lat;
        pipe_adv   = v.adv;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        // rst valid rs rsu rt rtu rd wr lat adv chk stall busy count
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));     // reset, reader of r3
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0));
        // load-use on r5
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 1, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 1, 32'h20, 0));
        vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 1));
        // latency 3 on r7, consumer via rt, freeze for two cycles
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 3, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 1, 1, 32'h80, 1));
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, 32'h80, 2));
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, 32'h80, 3));
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 1, 1, 32'h80, 4));
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 1, 1, 32'h80, 5));
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 1, 0, 32'h0, 6));
        // WAW on r9: L=4 then L=1
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 4, 1, 1, 0, 32'h0, 6));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 1, 32'h200, 6));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 1, 32'h200, 7));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 1, 32'h200, 8));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 0, 32'h200, 9));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h200, 9));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 9));
        // r0 is never tracked
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 4, 1, 1, 0, 32'h0, 9));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 32'h0, 9));
        // lat 7 clamps to 4: a lat-3 write to r2 waits exactly one cycle
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 7, 1, 1, 0, 32'h0, 9));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 3, 1, 1, 1, 32'h4, 9));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 3, 1, 1, 0, 32'h4, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h4, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h4, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h4, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 10));
        // reset mid-flight discards the r11 entry
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 11, 1, 4, 1, 1, 0, 32'h0, 10));
        vecs.push_back(mk(1, 1, 11, 1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h800, 10));
        vecs.push_back(mk(0, 1, 11, 1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("stall_if[%0d]", i), {31'b0, stall_if}, {31'b0, vecs[i].exp_stall});
            checkOutput($sformatf("stall_id[%0d]", i), {31'b0, stall_id}, {31'b0, vecs[i].exp_stall});
            if (vecs[i].chk_state) begin
                checkOutput($sformatf("busy[%0d]", i), busy, vecs[i].exp_busy);
                checkOutput($sformatf("stall_count[%0d]", i), stall_count, vecs[i].exp_cnt);
            end
        end

        // Saturation: r13 busy, consumer held frozen for 20 hazard cycles
        @(negedge clk);
        applyStimulus(mk(0, 1, 0, 0, 0, 0, 13, 1, 4, 1, 0, 0, 32'h0, 0));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            applyStimulus(mk(0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
            #1;
            checkOutput($sformatf("sat_stall[%0d]", k), {31'b0, sat_stall_if}, 32'd1);
        end
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        #1;
        checkOutput("sat_count", {28'b0, sat_count}, 32'd15);
        checkOutput("wide_count", stall_count, 32'd20);
        checkOutput("sat_busy_frozen", busy, 32'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
